// File: rtl/encoder4x2_seq_pkg.sv
// Shared constants, FSM state type and lowest-set-bit helper for the sequential 4-to-2 encoder.
package encoder_pkg;
  localparam int N_IN  = 4;
  localparam int W_OUT = 2;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  // Scan from the top down so the last hit wins: the lowest set bit.
  function automatic logic [W_OUT-1:0] lowest_set_idx(input logic [N_IN-1:0] v);
    logic [W_OUT-1:0] idx;
    idx = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (v[i]) idx = W_OUT'(i);
    return idx;
  endfunction
endpackage

// File: rtl/encoder4x2_seq_prio_enc4.sv
// Combinational lowest-set-bit encoder with an any-bit-set flag.
module prio_enc4
  import encoder_pkg::*;
(
  input  logic [N_IN-1:0]  vec,
  output logic [W_OUT-1:0] idx,
  output logic             any
);
  assign idx = lowest_set_idx(vec);
  assign any = |vec;
endmodule

// File: rtl/encoder4x2_seq.sv
// Sequential 4-to-2 encoder: accepts a request vector, then emits each set index lowest first.
// Optional out_last port enabled by defining ENCODER4X2_SEQ_LAST_EN.
module encoder4x2_seq
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_OUT-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ENCODER4X2_SEQ_LAST_EN
  output logic             out_last,
`endif
  output logic             zero_err
);
  state_e          state_q, state_d;
  logic [N_IN-1:0] pending_q, pending_d;
  logic            zero_err_q, zero_err_d;
  logic [W_OUT-1:0] pend_idx;
  logic            pend_any;

  prio_enc4 u_prio (
    .vec (pending_q),
    .idx (pend_idx),
    .any (pend_any)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    result     = '0;
    case (state_q)
      IDLE: begin
        // rst gating keeps in_ready low for the whole reset window, not just after the edge.
        in_ready = en && !rst;
        if (in_valid && in_ready) begin
          if (in != '0) begin
            pending_d = in;
            state_d   = EMIT;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        out_valid = en;
        result    = pend_idx;
        if (out_valid && out_ready) begin
          pending_d = pending_q & ~(N_IN'(1) << pend_idx);
          if (pending_d == '0) state_d = IDLE;
        end
        if (!pend_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ENCODER4X2_SEQ_LAST_EN
  // Exactly one bit left means the current index is the final one.
  assign out_last = out_valid && pend_any && ((pending_q & (pending_q - N_IN'(1))) == '0);
`endif

  assign zero_err = zero_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end
endmodule

// File: tb/tb_encoder4x2_seq.sv
// Randomized plus directed bench for encoder4x2_seq against a queue-of-indices reference model.
module tb_encoder4x2_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] result;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       zero_err;
`ifdef ENCODER4X2_SEQ_LAST_EN
  logic       out_last;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the indices still to be emitted, lowest first; non-empty means emitting.
  int   m_q[$];
  logic m_zero = 1'b0;

  encoder4x2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ENCODER4X2_SEQ_LAST_EN
    .out_last  (out_last),
`endif
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {3'b0, in_ready}, 4'd0);
    chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
    chk("rst_result", {2'b0, result}, 4'd0);
    chk("rst_zero_err", {3'b0, zero_err}, 4'd0);
`ifdef ENCODER4X2_SEQ_LAST_EN
    chk("rst_out_last", {3'b0, out_last}, 4'd0);
`endif
    m_q.delete();
    m_zero = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance across the edge.
  task automatic step(input logic e, input logic iv, input logic orr, input logic [3:0] v);
    logic exp_ir, exp_ov, nz;
    logic [1:0] exp_res;
    en = e; in_valid = iv; out_ready = orr; in = v;
    #1;
    exp_ir  = (m_q.size() == 0) && e;
    exp_ov  = (m_q.size() != 0) && e;
    exp_res = (m_q.size() != 0) ? 2'(m_q[0]) : 2'd0;
    chk("in_ready", {3'b0, in_ready}, {3'b0, exp_ir});
    chk("out_valid", {3'b0, out_valid}, {3'b0, exp_ov});
    chk("result", {2'b0, result}, {2'b0, exp_res});
    chk("zero_err", {3'b0, zero_err}, {3'b0, m_zero});
`ifdef ENCODER4X2_SEQ_LAST_EN
    chk("out_last", {3'b0, out_last}, {3'b0, exp_ov && (m_q.size() == 1)});
`endif
    nz = 1'b0;
    @(posedge clk);
    if (exp_ir && iv) begin
      if (v != 4'd0) begin
        for (int i = 0; i < 4; i++) if (v[i]) m_q.push_back(i);
      end else nz = 1'b1;
    end else if (exp_ov && orr) begin
      void'(m_q.pop_front());
    end
    m_zero = nz;
    #1;
  endtask

  initial begin
    logic [3:0] v;
    #1;
    do_reset();

    // Reset while emitting 1010: first result checked, then reset mid-vector.
    step(1, 1, 1, 4'b1010);
    step(1, 0, 1, 4'b0000);
    do_reset();
    step(1, 0, 1, 4'b0000);

    // One-hot sweep with a decode round-trip.
    for (int i = 0; i < 4; i++) begin
      v = 4'b0001 << i;
      step(1, 1, 1, v);
      chk("roundtrip", 4'b0001 << result, v);
      step(1, 0, 1, 4'b0000);
    end

    // Multi-hot 1101: 00, 10, 11 then idle.
    step(1, 1, 1, 4'b1101);
    repeat (3) step(1, 0, 1, 4'b0000);
    step(1, 0, 1, 4'b0000);

    // Backpressure on 0110.
    step(1, 1, 0, 4'b0110);
    repeat (3) step(1, 0, 0, 4'b1111);
    repeat (2) step(1, 0, 1, 4'b0000);

    // Enable pause mid-vector on 1001.
    step(1, 1, 1, 4'b1001);
    repeat (2) step(0, 1, 1, 4'b0101);
    repeat (2) step(1, 0, 1, 4'b0000);

    // Zero vector accept.
    step(1, 1, 1, 4'b0000);
    step(1, 0, 1, 4'b0000);
    step(1, 0, 1, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
